pimp_mc_core: RTL
=================

# pimp_mc_core

Parametrised multicycle successor to the single-cycle PIMP top level. It executes the same 9-bit instruction format, but in FSM-sequenced phases. Instruction and data memories are external and reached through ports; data memory uses a req/ack handshake with arbitrary wait states. The block adds a Start/Done handshake, a HALT instruction and a retired-instruction counter.

## Interface
Parameters:
- DATA_W, 8: register/ALU/data-memory width (≥ 8).
- PC_W, 8: program counter and instruction address width (≥ 6).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Start  in  1  launch pulse; sampled in IDLE and HALT only.
- Start_Addr  in  PC_W  first instruction address, captured with Start.
- Imem_Addr  out  PC_W  instruction address (= PC).
- Imem_Data  in  9  instruction; combinational ROM, valid in the same cycle.
- Dmem_Req  out  1  data-memory request.
- Dmem_We  out  1  1 = store, 0 = load; valid while Dmem_Req = 1.
- Dmem_Addr  out  DATA_W  address, always R6.
- Dmem_Wdata  out  DATA_W  store data (register r1).
- Dmem_Rdata  in  DATA_W  load data; valid in a cycle where Dmem_Ack = 1.
- Dmem_Ack  in  1  completes the pending request.
- Busy  out  1  high in FETCH, EXEC and MEM.
- Done  out  1  high in HALT.
- Instr_Count  out  CNT_W  instructions retired since the last Start.

## Operation
- Instruction fields: op = [8:6], r1 = [5:3], r2 = [2:0], off = [5:0].
- There are 8 registers R0–R7 of DATA_W bits. The destination is always r1.
- Opcodes:
  - 000 ADD: r1 = r1 + r2.
  - 001 SUB: r1 = r1 − r2.
  - 010 AND: r1 = r1 & r2.
  - 011 SHL: r1 = r1 << r2, where the r2 field is a 3-bit immediate.
  - 100 LOAD: r1 = mem[R6].
  - 101 STORE: mem[R6] = r1.
  - 110 BEQ: if R0 == R1 then PC = PC + sext(off), else PC = PC + 1.
  - 111 with r1 = r2 = 111: HALT.
  - 111 otherwise: COPY, r1 = r2.
- Arithmetic is modulo 2^DATA_W; carry and borrow are discarded. PC arithmetic is modulo 2^PC_W, and off is sign-extended to PC_W.
- All non-BEQ, non-HALT instructions set PC = PC + 1.
- FSM states: IDLE, FETCH, EXEC, MEM, HALT.
  - IDLE: on Start, PC ← Start_Addr, Instr_Count ← 0, go to FETCH.
  - FETCH: IR ← Imem_Data, go to EXEC.
  - EXEC: ALU/SHL/COPY writes r1, updates PC and goes to FETCH. BEQ updates PC and goes to FETCH. LOAD/STORE goes to MEM. HALT goes to HALT with PC unchanged.
  - MEM: Dmem_Req = 1, with Dmem_We, Dmem_Addr and Dmem_Wdata held stable. Remain in MEM until Dmem_Ack. On Ack: a LOAD writes Dmem_Rdata to r1; PC + 1; go to FETCH.
  - HALT: Done = 1. Start restarts exactly as it does from IDLE.
- Instr_Count increments by 1 on each retire and saturates at all-ones. Retire points are: EXEC of ALU/SHL/COPY/BEQ, and MEM with Ack. HALT is not counted.
- Start is ignored while Busy.
- Registers keep their values across Start. They are cleared only by reset.

## Timing
- Reset (Reset_n = 0 at a rising edge) has the following effect:
  - State returns to IDLE.
  - PC, IR, R0–R7 and Instr_Count are cleared to 0.
  - Busy, Done, Dmem_Req and Dmem_We are 0.
  - Imem_Addr, Dmem_Addr and Dmem_Wdata are 0.
- Reset overrides everything, including Start and Dmem_Ack in the same cycle. A reset during MEM drops Dmem_Req on the next cycle and performs no register write.
- Per-instruction latency:
  - ALU/SHL/COPY/BEQ take 2 cycles.
  - LOAD/STORE take 3 + w cycles, where w = number of MEM cycles without Ack.
  - From Start to the first FETCH is 1 cycle.
- Dmem_Ack is ignored outside MEM.
- Register writes take effect at the end of EXEC or MEM and are visible to the next FETCH/EXEC. There is no forwarding hazard because execution is strictly sequential.
- Done rises in the cycle after the EXEC of HALT. It stays high until Start or reset, and falls in the cycle after Start.

## Test plan
- R2 = 5 and R3 = 250 preset via LOAD, DATA_W = 8, then ADD R2,R3 → R2 = 255. Then SUB R2,R3 → R2 = 5. Instr_Count = 4.
- SHL R4,3 with R4 = 0x21 → R4 = 0x08.
- COPY R5,R4 → R5 = 0x08, and each of these instructions takes 2 cycles.
- BEQ with R0 = R1 and off = 0x3E (−2) at PC 10 → PC = 8. With R0 ≠ R1 → PC = 11. A PC_W = 8 program at PC 0x01 with off = −2 → PC = 0xFF (wrap).
- LOAD with Dmem_Ack delayed 2 cycles → Dmem_Req is high for 3 cycles with Dmem_Addr = R6 stable, r1 = Dmem_Rdata, and the instruction takes 5 cycles in total. STORE → Dmem_We = 1, Dmem_Wdata = r1.
- HALT at address 4 after Start_Addr = 0 → Done = 1 after 4 retires, Busy = 0, Instr_Count = 4. Start is ignored while Busy. Start in HALT restarts and zeroes Instr_Count.
- Reset_n = 0 during MEM with Ack high the same cycle → no register write; next cycle IDLE with all outputs 0.
- CNT_W = 2 with a loop of 5 instructions → Instr_Count saturates at 3.

Source files
------------

// File: rtl/pimp_mc_core.sv
// pimp_mc_core: multicycle PIMP core executing 9-bit instructions in FETCH/EXEC/MEM
// phases, with an external combinational instruction ROM and a req/ack data memory.
module pimp_mc_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [PC_W-1:0]   Start_Addr,
  output logic [PC_W-1:0]   Imem_Addr,
  input  logic [8:0]        Imem_Data,
  output logic              Dmem_Req,
  output logic              Dmem_We,
  output logic [DATA_W-1:0] Dmem_Addr,
  output logic [DATA_W-1:0] Dmem_Wdata,
  input  logic [DATA_W-1:0] Dmem_Rdata,
  input  logic              Dmem_Ack,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  Instr_Count,
  output logic [2:0]        Dbg_State
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_SHL   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;
  localparam logic [2:0] OP_BEQ   = 3'd6;

  state_t            state;
  state_t            nextState;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pcNext;
  logic [PC_W-1:0]   offExt;
  logic [8:0]        ir;
  logic [DATA_W-1:0] regFile [8];
  logic [CNT_W-1:0]  instrCount;
  logic [2:0]        op;
  logic [2:0]        rd;
  logic [2:0]        rs;
  logic [DATA_W-1:0] rdVal;
  logic [DATA_W-1:0] rsVal;
  logic [DATA_W-1:0] regWdata;
  logic              regWe;
  logic              retire;
  logic              isHalt;
  logic              startAccept;

  assign op          = ir[8:6];
  assign rd          = ir[5:3];
  assign rs          = ir[2:0];
  assign rdVal       = regFile[rd];
  assign rsVal       = regFile[rs];
  assign isHalt      = (op == 3'b111) && (rd == 3'b111) && (rs == 3'b111);
  assign offExt      = PC_W'($signed(ir[5:0]));
  assign startAccept = ((state == S_IDLE) || (state == S_HALT)) && Start;

  // Data-memory handshake: Dmem_Req is held high for the whole MEM phase with
  // Dmem_We/Dmem_Addr/Dmem_Wdata stable; the transfer completes in the first
  // cycle where Dmem_Ack is sampled high, and Dmem_Rdata is only used then.
  assign Dmem_Req    = (state == S_MEM);
  assign Dmem_We     = (state == S_MEM) && (op == OP_STORE);
  assign Dmem_Addr   = regFile[6];
  assign Dmem_Wdata  = rdVal;
  assign Imem_Addr   = pc;
  assign Busy        = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
  assign Done        = (state == S_HALT);
  assign Instr_Count = instrCount;
  assign Dbg_State   = state;

  always_comb begin
    nextState = state;
    pcNext    = pc;
    regWe     = 1'b0;
    regWdata  = rdVal;
    retire    = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (Start) nextState = S_FETCH;
      end
      S_FETCH: nextState = S_EXEC;
      S_EXEC: begin
        nextState = S_FETCH;
        pcNext    = pc + PC_W'(1);
        retire    = 1'b1;
        case (op)
          OP_ADD: begin regWe = 1'b1; regWdata = rdVal + rsVal; end
          OP_SUB: begin regWe = 1'b1; regWdata = rdVal - rsVal; end
          OP_AND: begin regWe = 1'b1; regWdata = rdVal & rsVal; end
          OP_SHL: begin regWe = 1'b1; regWdata = rdVal << rs; end
          OP_LOAD, OP_STORE: begin
            // PC and retire are deferred until the memory transfer completes
            nextState = S_MEM;
            pcNext    = pc;
            retire    = 1'b0;
          end
          OP_BEQ: begin
            if (regFile[0] == regFile[1]) pcNext = pc + offExt;
          end
          default: begin
            if (isHalt) begin
              nextState = S_HALT;
              pcNext    = pc;
              retire    = 1'b0;
            end else begin
              regWe    = 1'b1;
              regWdata = rsVal;
            end
          end
        endcase
      end
      S_MEM: begin
        if (Dmem_Ack) begin
          nextState = S_FETCH;
          pcNext    = pc + PC_W'(1);
          retire    = 1'b1;
          regWe     = (op == OP_LOAD);
          regWdata  = Dmem_Rdata;
        end
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      instrCount <= '0;
      for (int i = 0; i < 8; i++) regFile[i] <= '0;
    end else begin
      state <= nextState;
      if (state == S_FETCH) ir <= Imem_Data;
      if (startAccept) begin
        pc         <= Start_Addr;
        instrCount <= '0;
      end else begin
        pc <= pcNext;
        if (retire && (instrCount != {CNT_W{1'b1}})) instrCount <= instrCount + CNT_W'(1);
      end
      if (regWe) regFile[rd] <= regWdata;
    end
  end

endmodule
